// File: rtl/fir_cfg_master.sv
// fir_cfg_master: AXI-Lite initiator that writes data_length and taps into the fir block, optionally reads taps back, starts it and polls ap_done.
// Latency: one idle cycle after every beat before the next is issued; status polls are separated by at least pPOLL_GAP idle cycles.
// Backpressure: each beat waits indefinitely on awready/wready/arready/rvalid; only one beat is ever outstanding.
module fir_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pTAP_STRIDE = 1,
  parameter int pPOLL_GAP   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cmd_start,
  input  logic                   cmd_verify,
  input  logic [31:0]            cfg_len,
  input  logic [Tape_Num*32-1:0] coef_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [31:0]            status,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  localparam int TW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam int GW = $clog2(pPOLL_GAP + 1);
  localparam logic [TW-1:0] LAST_TAP = TW'(Tape_Num - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(pPOLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_TAP,
    S_RD_TAP,
    S_WR_START,
    S_POLL_GAP,
    S_POLL
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tap_idx;
  logic [GW-1:0]          gap_cnt;
  // launch: the current state still has to present its beat on the bus
  logic                   launch;
  logic                   aw_ok;
  logic                   w_ok;
  logic                   rd_pend;
  logic                   verify_q;
  logic [31:0]            len_q;
  logic [31:0]            coef_q [Tape_Num];

  logic [31:0]            tap_val;
  logic [pADDR_WIDTH-1:0] tap_addr;
  logic [pADDR_WIDTH-1:0] beat_addr;
  logic [pDATA_WIDTH-1:0] beat_data;
  logic                   wr_fin;
  logic                   rd_fin;

  // Tap value/address for the current index; address wraps at pADDR_WIDTH
  always_comb begin
    tap_val  = coef_q[tap_idx];
    tap_addr = pADDR_WIDTH'(32'h20 + 32'(tap_idx) * 32'(pTAP_STRIDE));
  end

  // Address and data of the beat the current state issues
  always_comb begin
    beat_addr = '0;
    beat_data = pDATA_WIDTH'(32'd1);
    case (state)
      S_WR_LEN: begin
        beat_addr = pADDR_WIDTH'(32'h10);
        beat_data = pDATA_WIDTH'(len_q);
      end
      S_WR_TAP, S_RD_TAP: begin
        beat_addr = tap_addr;
        beat_data = pDATA_WIDTH'(tap_val);
      end
      default: begin
        beat_addr = '0;
        beat_data = pDATA_WIDTH'(32'd1);
      end
    endcase
  end

  // A write beat ends once both channels have handshaked, in either order
  always_comb begin
    wr_fin = (aw_ok | (awvalid & awready)) & (w_ok | (wvalid & wready));
    rd_fin = rd_pend & rvalid & rready;
  end

  // Sequencer FSM with all bus outputs registered
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state    <= S_IDLE;
      tap_idx  <= '0;
      gap_cnt  <= '0;
      launch   <= 1'b0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      rd_pend  <= 1'b0;
      verify_q <= 1'b0;
      len_q    <= '0;
      for (int i = 0; i < Tape_Num; i++) coef_q[i] <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      status   <= '0;
      awvalid  <= 1'b0;
      awaddr   <= '0;
      wvalid   <= 1'b0;
      wdata    <= '0;
      arvalid  <= 1'b0;
      araddr   <= '0;
      rready   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            len_q    <= cfg_len;
            verify_q <= cmd_verify;
            for (int i = 0; i < Tape_Num; i++) coef_q[i] <= coef_flat[i*32 +: 32];
            cfg_err  <= 1'b0;
            busy     <= 1'b1;
            tap_idx  <= '0;
            launch   <= 1'b1;
            state    <= S_WR_LEN;
          end
        end

        S_WR_LEN, S_WR_TAP, S_WR_START: begin
          if (launch) begin
            launch  <= 1'b0;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= beat_addr;
            wdata   <= beat_data;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
          end else begin
            if (awvalid && awready) begin
              awvalid <= 1'b0;
              aw_ok   <= 1'b1;
            end
            if (wvalid && wready) begin
              wvalid <= 1'b0;
              w_ok   <= 1'b1;
            end
            if (wr_fin) begin
              aw_ok <= 1'b0;
              w_ok  <= 1'b0;
              case (state)
                S_WR_LEN: begin
                  state  <= S_WR_TAP;
                  launch <= 1'b1;
                end
                S_WR_TAP: begin
                  launch <= 1'b1;
                  if (tap_idx == LAST_TAP) begin
                    tap_idx <= '0;
                    if (verify_q) begin
                      state  <= S_RD_TAP;
                      rready <= 1'b1;
                    end else begin
                      state <= S_WR_START;
                    end
                  end else begin
                    tap_idx <= tap_idx + 1'b1;
                  end
                end
                default: begin
                  gap_cnt <= '0;
                  state   <= S_POLL_GAP;
                end
              endcase
            end
          end
        end

        S_RD_TAP, S_POLL: begin
          if (launch) begin
            launch  <= 1'b0;
            arvalid <= 1'b1;
            araddr  <= beat_addr;
            rd_pend <= 1'b1;
          end else begin
            if (arvalid && arready) arvalid <= 1'b0;
            if (rd_fin) begin
              rd_pend <= 1'b0;
              arvalid <= 1'b0;
              if (state == S_RD_TAP) begin
                // A mismatch is recorded but never stops the sequence
                if (rdata != pDATA_WIDTH'(tap_val)) cfg_err <= 1'b1;
                launch <= 1'b1;
                if (tap_idx == LAST_TAP) begin
                  tap_idx <= '0;
                  rready  <= 1'b0;
                  state   <= S_WR_START;
                end else begin
                  tap_idx <= tap_idx + 1'b1;
                end
              end else begin
                status <= 32'(rdata);
                rready <= 1'b0;
                if (rdata[1]) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  gap_cnt <= '0;
                  state   <= S_POLL_GAP;
                end
              end
            end
          end
        end

        S_POLL_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state  <= S_POLL;
            launch <= 1'b1;
            rready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Bench for fir_cfg_master: behavioural AXI-Lite responder with selectable
// ready patterns, a write/read scoreboard and directed command sequences.
module tb_fir_cfg_master;

  localparam int TAPS = 11;
  localparam int GAP  = 4;

  logic              axis_clk = 1'b0;
  logic              axis_rst;
  logic              cmd_start;
  logic              cmd_verify;
  logic [31:0]       cfg_len;
  logic [TAPS*32-1:0] coef_flat;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [31:0]       status;
  logic              awvalid;
  logic [11:0]       awaddr;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic              wready;
  logic              arvalid;
  logic [11:0]       araddr;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              rready;

  fir_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS), .pTAP_STRIDE(1), .pPOLL_GAP(GAP)
  ) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .cmd_start(cmd_start), .cmd_verify(cmd_verify), .cfg_len(cfg_len), .coef_flat(coef_flat),
    .busy(busy), .done(done), .cfg_err(cfg_err), .status(status),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected {addr, data} writes and expected read addresses
  logic [43:0] exp_wr [$];
  logic [11:0] exp_rd [$];
  logic [11:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [31:0] status_q [$];
  logic [31:0] mem [256];
  logic [31:0] cur_taps [TAPS];
  int          taps_a [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  // responder modes and monitor state
  bit   stagger = 0, stall = 0, rsame = 0, corrupt_en = 0;
  bit   prev_aw = 0, prev_w = 0, prev_ar = 0, prev_r = 0;
  logic [11:0] ar_addr_s = '0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, last_poll = -1, min_gap = 1000;
  bit   rs_aw_got = 0, rs_w_got = 0;
  int   rs_beat = 0, rs_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [11:0] a);
    if (a == 12'h000) return (status_q.size() > 0) ? status_q.pop_front() : 32'h2;
    if (corrupt_en && a == 12'h025) return 32'd62;
    return mem[a[7:0]];
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will see
  always @(negedge axis_clk) begin
    logic [11:0] a;
    logic [31:0] d;
    logic [43:0] e;
    logic [11:0] ea;
    cyc++;
    if (axis_rst) begin
      aw_q.delete();
      wd_q.delete();
      prev_aw = 0; prev_w = 0; prev_ar = 0; prev_r = 0;
    end else begin
      if (prev_aw) chk("awvalid_drop", 64'(awvalid), 64'd0);
      if (prev_w)  chk("wvalid_drop", 64'(wvalid), 64'd0);
      if (prev_aw && aw_q.size() > 0) chk("wvalid_hold", 64'(wvalid), 64'd1);
      if (prev_w && wd_q.size() > 0)  chk("awvalid_hold", 64'(awvalid), 64'd1);
      if (prev_ar) chk("arvalid_drop", 64'(arvalid), 64'd0);
      prev_aw = awvalid && awready;
      prev_w  = wvalid && wready;
      prev_ar = arvalid && arready;
      prev_r  = rvalid && rready;
      if (prev_aw) aw_q.push_back(awaddr);
      if (prev_w)  wd_q.push_back(wdata);
      while (aw_q.size() > 0 && wd_q.size() > 0) begin
        a = aw_q.pop_front();
        d = wd_q.pop_front();
        wr_cnt++;
        mem[a[7:0]] = d;
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 44'bx;
        chk("wr_beat", 64'({a, d}), 64'(e));
      end
      if (prev_ar) begin
        ar_addr_s = araddr;
        ea = (exp_rd.size() > 0) ? exp_rd.pop_front() : 12'bx;
        chk("rd_addr", 64'(araddr), 64'(ea));
        if (araddr == 12'h000) begin
          if (last_poll >= 0 && (cyc - last_poll - 1) < min_gap) min_gap = cyc - last_poll - 1;
          last_poll = cyc;
        end
      end
      if (done) done_cnt++;
    end
  end

  // Responder: reacts just after each rising edge to the handshakes taken there
  always @(posedge axis_clk) begin
    bit lead_aw, lead_got;
    #1;
    if (axis_rst) begin
      rs_aw_got = 0; rs_w_got = 0; rs_cnt = 0;
      rvalid = 1'b0;
    end else begin
      if (prev_aw) rs_aw_got = 1;
      if (prev_w)  rs_w_got = 1;
      if (rs_aw_got && rs_w_got) begin
        rs_aw_got = 0; rs_w_got = 0; rs_beat++; rs_cnt = 0;
      end
      if (stall) begin
        awready = 1'b0; wready = 1'b1;
      end else if (!stagger) begin
        awready = 1'b1; wready = 1'b1;
      end else begin
        lead_aw  = (rs_beat % 2) == 0;
        lead_got = lead_aw ? rs_aw_got : rs_w_got;
        if (lead_got) rs_cnt++;
        awready = lead_aw ? !lead_got : (lead_got && rs_cnt >= 3);
        wready  = lead_aw ? (lead_got && rs_cnt >= 3) : !lead_got;
      end
      if (prev_r) rvalid = 1'b0;
      arready = 1'b1;
      if (rsame) begin
        if (arvalid) begin
          rvalid = 1'b1;
          rdata  = rd_val(araddr);
        end
      end else if (prev_ar) begin
        rvalid = 1'b1;
        rdata  = rd_val(ar_addr_s);
      end
    end
  end

  task automatic step();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic launch_seq(input logic v, input logic [31:0] len, input int npolls);
    exp_wr.push_back({12'h010, len});
    for (int k = 0; k < TAPS; k++) exp_wr.push_back({12'(32'h20 + k), cur_taps[k]});
    exp_wr.push_back({12'h000, 32'h1});
    if (v) for (int k = 0; k < TAPS; k++) exp_rd.push_back(12'(32'h20 + k));
    for (int p = 0; p < npolls; p++) exp_rd.push_back(12'h000);
    for (int k = 0; k < TAPS; k++) coef_flat[k*32 +: 32] = cur_taps[k];
    step();
    cmd_start = 1'b1; cmd_verify = v; cfg_len = len;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input logic [31:0] st, input logic err, input int dcnt);
    for (int i = 0; i < 3000; i++) begin
      @(negedge axis_clk);
      if (done) break;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_status"}, 64'(status), 64'(st));
    chk({tag, "_cfg_err"}, 64'(cfg_err), 64'(err));
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
    @(negedge axis_clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_after"}, 64'(done), 64'd0);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(dcnt));
  endtask

  initial begin
    axis_rst = 1'b1; cmd_start = 1'b0; cmd_verify = 1'b0; cfg_len = '0; coef_flat = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
    chk("rst_addr_data", 64'({awaddr, araddr, wdata}), 64'd0);
    chk("rst_flags", 64'({busy, done, cfg_err}), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    step();
    axis_rst = 1'b0;

    // 1: plain write sequence, three status polls
    for (int k = 0; k < TAPS; k++) cur_taps[k] = 32'(taps_a[k]);
    status_q = '{32'h0, 32'h0, 32'h2};
    wr_cnt = 0; last_poll = -1; min_gap = 1000;
    launch_seq(1'b0, 32'd600, 3);
    chk("t1_busy", 64'(busy), 64'd1);
    finish_run("t1", 32'h2, 1'b0, 1);
    chk("t1_wr_count", 64'(wr_cnt), 64'd13);
    chk("t1_poll_gap_ok", 64'(min_gap >= GAP), 64'd1);

    // 2a: verify with matching read-back, rvalid alongside arready
    rsame = 1;
    status_q = '{32'h2};
    launch_seq(1'b1, 32'd600, 1);
    finish_run("t2a", 32'h2, 1'b0, 2);
    rsame = 0;

    // 2b: tap 5 read back corrupted
    corrupt_en = 1;
    status_q = '{32'h0, 32'h2};
    launch_seq(1'b1, 32'd600, 2);
    finish_run("t2b", 32'h2, 1'b1, 3);
    corrupt_en = 0;

    // 3: staggered awready/wready, random taps; cfg_err clears on accept
    stagger = 1;
    for (int k = 0; k < TAPS; k++) cur_taps[k] = $urandom;
    status_q = '{32'h2};
    wr_cnt = 0;
    launch_seq(1'b0, 32'd77, 1);
    chk("t3_err_cleared", 64'(cfg_err), 64'd0);
    finish_run("t3", 32'h2, 1'b0, 4);
    chk("t3_wr_count", 64'(wr_cnt), 64'd13);
    stagger = 0;

    // 5: second cmd_start mid tap writes must be ignored
    for (int k = 0; k < TAPS; k++) cur_taps[k] = 32'(taps_a[k]);
    status_q = '{32'h2};
    launch_seq(1'b0, 32'd600, 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge axis_clk);
      if (awvalid && awaddr == 12'h023) break;
    end
    chk("t5_reached_tap3", 64'(awaddr), 64'h023);
    step();
    cmd_start = 1'b1; cmd_verify = 1'b1; cfg_len = 32'd999; coef_flat = ~coef_flat;
    step();
    cmd_start = 1'b0;
    finish_run("t5", 32'h2, 1'b0, 5);

    // 6: reset while awvalid is stalled, then a clean restart
    stall = 1;
    status_q = '{32'h2};
    launch_seq(1'b0, 32'd600, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge axis_clk);
      if (awvalid) break;
    end
    repeat (3) @(negedge axis_clk);
    chk("t6_aw_stalled", 64'(awvalid), 64'd1);
    step();
    axis_rst = 1'b1;
    @(posedge axis_clk);
    @(negedge axis_clk);
    chk("t6_rst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    step();
    axis_rst = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    stall = 0;
    status_q = '{32'h2};
    wr_cnt = 0;
    launch_seq(1'b0, 32'd55, 1);
    finish_run("t6", 32'h2, 1'b0, 6);
    chk("t6_wr_count", 64'(wr_cnt), 64'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
